// File: rtl/id_stage_pipe.sv
// MIPS ID stage: decode, forwarded operand read, load-use scoreboard and a valid/ready ID/EX register.
// Optional macro ID_SQUASH_EN squashes the fall-through fetch after a taken branch/jump (no delay slot).
module id_stage_pipe #(
   parameter  int unsigned NFWD     = 2,
   parameter  int unsigned LOAD_LAT = 1,
   localparam int unsigned ALUOP_W  = 8,
   localparam int unsigned ALUSEL_W = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_valid_i,
   output logic                  if_ready_o,
   input  logic [31:0]           pc_i,
   input  logic [31:0]           inst_i,
   output logic [4:0]            raddr1_o,
   output logic [4:0]            raddr2_o,
   input  logic [31:0]           rdata1_i,
   input  logic [31:0]           rdata2_i,
   input  logic [NFWD-1:0]       fwd_we_i,
   input  logic [5*NFWD-1:0]     fwd_waddr_i,
   input  logic [32*NFWD-1:0]    fwd_wdata_i,
   input  logic                  flush_i,
   input  logic                  ex_ready_i,
   output logic                  ex_valid_o,
   output logic [ALUOP_W-1:0]    aluop_o,
   output logic [ALUSEL_W-1:0]   alusel_o,
   output logic [31:0]           op1_o,
   output logic [31:0]           op2_o,
   output logic [4:0]            waddr_o,
   output logic                  we_o,
   output logic [31:0]           laddr_o,
   output logic                  mre_o,
   output logic                  mwe_o,
   output logic [31:0]           mwdata_o,
   output logic                  be_o,
   output logic [31:0]           baddr_o,
   output logic                  exc_o,
   output logic [31:0]           exc_pc_o
);

   localparam logic [ALUOP_W-1:0] ALU_NOP = 8'd0, ALU_ADD = 8'd1, ALU_ADDU = 8'd2, ALU_SUB = 8'd3,
      ALU_SUBU = 8'd4, ALU_AND = 8'd5, ALU_OR = 8'd6, ALU_XOR = 8'd7, ALU_NOR = 8'd8, ALU_SLT = 8'd9,
      ALU_SLTU = 8'd10, ALU_SLL = 8'd11, ALU_SRL = 8'd12, ALU_SRA = 8'd13, ALU_LINK = 8'd14;
   localparam logic [ALUSEL_W-1:0] SEL_NOP = 3'd0, SEL_LOGIC = 3'd1, SEL_SHIFT = 3'd2, SEL_ARITH = 3'd3,
      SEL_JUMP = 3'd4, SEL_LOAD = 3'd5, SEL_STORE = 3'd6;
   localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05,
      OP_BLEZ = 6'h06, OP_BGTZ = 6'h07, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
      OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
   localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04, F_SRLV = 6'h06,
      F_SRAV = 6'h07, F_JR = 6'h08, F_JALR = 6'h09, F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22,
      F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;

   typedef struct packed {
      logic                valid;
      logic [ALUOP_W-1:0]  aluop;
      logic [ALUSEL_W-1:0] alusel;
      logic [31:0]         op1;
      logic [31:0]         op2;
      logic [4:0]          waddr;
      logic                we;
      logic [31:0]         laddr;
      logic                mre;
      logic                mwe;
      logic [31:0]         mwdata;
   } idex_t;

   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm;
   assign opcode = inst_i[31:26];
   assign rs     = inst_i[25:21];
   assign rt     = inst_i[20:16];
   assign rd     = inst_i[15:11];
   assign shamt  = inst_i[10:6];
   assign funct  = inst_i[5:0];
   assign imm    = inst_i[15:0];

   logic                inst_ok, re1, re2, use_imm, use_shamt, dec_we;
   logic                is_lw, is_sw, is_link, is_j, is_jr, is_beq, is_bne, is_blez, is_bgtz;
   logic [4:0]          dec_waddr;
   logic [ALUOP_W-1:0]  dec_aluop;
   logic [ALUSEL_W-1:0] dec_alusel;
   logic [31:0]         imm_ext, rs_val, rt_val, op1_dec, op2_dec, pc_plus4, target;
   logic                taken, hazard, stall, accept, discard, squash_act;
   logic [31:0][2:0]    sb_q, sb_d;
   idex_t               idex_q, idex_d;
   logic                exc_q, exc_d;
   logic [31:0]         exc_pc_q, exc_pc_d, link_ofs;

   // Instruction decode
   always_comb begin
      inst_ok    = 1'b1;
      re1        = 1'b0;
      re2        = 1'b0;
      use_imm    = 1'b0;
      use_shamt  = 1'b0;
      dec_we     = 1'b0;
      dec_waddr  = rt;
      dec_aluop  = ALU_NOP;
      dec_alusel = SEL_NOP;
      is_lw      = 1'b0;
      is_sw      = 1'b0;
      is_link    = 1'b0;
      is_j       = 1'b0;
      is_jr      = 1'b0;
      is_beq     = 1'b0;
      is_bne     = 1'b0;
      is_blez    = 1'b0;
      is_bgtz    = 1'b0;
      case (opcode)
         OP_SPECIAL: begin
            dec_waddr  = rd;
            re1        = 1'b1;
            re2        = 1'b1;
            dec_we     = 1'b1;
            dec_alusel = SEL_ARITH;
            case (funct)
               F_SLL:  begin re1 = 1'b0; use_shamt = 1'b1; dec_alusel = SEL_SHIFT; dec_aluop = ALU_SLL; end
               F_SRL:  begin re1 = 1'b0; use_shamt = 1'b1; dec_alusel = SEL_SHIFT; dec_aluop = ALU_SRL; end
               F_SRA:  begin re1 = 1'b0; use_shamt = 1'b1; dec_alusel = SEL_SHIFT; dec_aluop = ALU_SRA; end
               F_SLLV: begin dec_alusel = SEL_SHIFT; dec_aluop = ALU_SLL; end
               F_SRLV: begin dec_alusel = SEL_SHIFT; dec_aluop = ALU_SRL; end
               F_SRAV: begin dec_alusel = SEL_SHIFT; dec_aluop = ALU_SRA; end
               F_JR:   begin re2 = 1'b0; dec_we = 1'b0; dec_alusel = SEL_NOP; is_jr = 1'b1; end
               F_JALR: begin re2 = 1'b0; dec_alusel = SEL_JUMP; dec_aluop = ALU_LINK; is_jr = 1'b1; is_link = 1'b1; end
               F_ADD:  dec_aluop = ALU_ADD;
               F_ADDU: dec_aluop = ALU_ADDU;
               F_SUB:  dec_aluop = ALU_SUB;
               F_SUBU: dec_aluop = ALU_SUBU;
               F_AND:  begin dec_alusel = SEL_LOGIC; dec_aluop = ALU_AND; end
               F_OR:   begin dec_alusel = SEL_LOGIC; dec_aluop = ALU_OR; end
               F_XOR:  begin dec_alusel = SEL_LOGIC; dec_aluop = ALU_XOR; end
               F_NOR:  begin dec_alusel = SEL_LOGIC; dec_aluop = ALU_NOR; end
               F_SLT:  dec_aluop = ALU_SLT;
               F_SLTU: dec_aluop = ALU_SLTU;
               default: begin
                  inst_ok    = 1'b0;
                  re1        = 1'b0;
                  re2        = 1'b0;
                  dec_we     = 1'b0;
                  dec_alusel = SEL_NOP;
               end
            endcase
         end
         OP_J:     is_j = 1'b1;
         OP_JAL:   begin is_j = 1'b1; is_link = 1'b1; dec_we = 1'b1; dec_waddr = 5'd31;
                         dec_alusel = SEL_JUMP; dec_aluop = ALU_LINK; end
         OP_BEQ:   begin re1 = 1'b1; re2 = 1'b1; is_beq = 1'b1; end
         OP_BNE:   begin re1 = 1'b1; re2 = 1'b1; is_bne = 1'b1; end
         OP_BLEZ:  begin re1 = 1'b1; is_blez = 1'b1; end
         OP_BGTZ:  begin re1 = 1'b1; is_bgtz = 1'b1; end
         OP_ADDI:  begin re1 = 1'b1; use_imm = 1'b1; dec_we = 1'b1; dec_alusel = SEL_ARITH; dec_aluop = ALU_ADD; end
         OP_ADDIU: begin re1 = 1'b1; use_imm = 1'b1; dec_we = 1'b1; dec_alusel = SEL_ARITH; dec_aluop = ALU_ADDU; end
         OP_SLTI:  begin re1 = 1'b1; use_imm = 1'b1; dec_we = 1'b1; dec_alusel = SEL_ARITH; dec_aluop = ALU_SLT; end
         OP_SLTIU: begin re1 = 1'b1; use_imm = 1'b1; dec_we = 1'b1; dec_alusel = SEL_ARITH; dec_aluop = ALU_SLTU; end
         OP_ANDI:  begin re1 = 1'b1; use_imm = 1'b1; dec_we = 1'b1; dec_alusel = SEL_LOGIC; dec_aluop = ALU_AND; end
         OP_ORI:   begin re1 = 1'b1; use_imm = 1'b1; dec_we = 1'b1; dec_alusel = SEL_LOGIC; dec_aluop = ALU_OR; end
         OP_XORI:  begin re1 = 1'b1; use_imm = 1'b1; dec_we = 1'b1; dec_alusel = SEL_LOGIC; dec_aluop = ALU_XOR; end
         OP_LUI:   begin use_imm = 1'b1; dec_we = 1'b1; dec_alusel = SEL_LOGIC; dec_aluop = ALU_OR; end
         OP_LW:    begin re1 = 1'b1; use_imm = 1'b1; dec_we = 1'b1; is_lw = 1'b1;
                         dec_alusel = SEL_LOAD; dec_aluop = ALU_ADDU; end
         OP_SW:    begin re1 = 1'b1; re2 = 1'b1; use_imm = 1'b1; is_sw = 1'b1;
                         dec_alusel = SEL_STORE; dec_aluop = ALU_ADDU; end
         default:  inst_ok = 1'b0;
      endcase
   end

   always_comb begin
      case (opcode)
         OP_ANDI, OP_ORI, OP_XORI: imm_ext = {16'h0, imm};
         OP_LUI:                   imm_ext = {imm, 16'h0};
         default:                  imm_ext = {{16{imm[15]}}, imm};
      endcase
   end

   // Operand read: r0 is hard zero, else lowest-index matching channel, else regfile
   always_comb begin
      rs_val = rdata1_i;
      rt_val = rdata2_i;
      for (int k = int'(NFWD) - 1; k >= 0; k--) begin
         if (fwd_we_i[k] && fwd_waddr_i[5*k +: 5] == rs) rs_val = fwd_wdata_i[32*k +: 32];
         if (fwd_we_i[k] && fwd_waddr_i[5*k +: 5] == rt) rt_val = fwd_wdata_i[32*k +: 32];
      end
      if (rs == 5'd0) rs_val = '0;
      if (rt == 5'd0) rt_val = '0;
   end

   assign op1_dec = use_shamt ? {27'b0, shamt} : (re1 ? rs_val : '0);
   assign op2_dec = use_imm ? imm_ext : (re2 ? rt_val : '0);

   // Branch/jump resolution
   assign pc_plus4 = pc_i + 32'd4;
   always_comb begin
      taken = is_j | is_jr
            | (is_beq & (rs_val == rt_val))
            | (is_bne & (rs_val != rt_val))
            | (is_blez & (rs_val[31] | (rs_val == 32'd0)))
            | (is_bgtz & ~rs_val[31] & (rs_val != 32'd0));
      if (is_j)       target = {pc_plus4[31:28], inst_i[25:0], 2'b00};
      else if (is_jr) target = rs_val;
      else            target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
   end

   assign hazard  = (re1 && sb_q[rs] != 3'd0) || (re2 && sb_q[rt] != 3'd0);
   assign stall   = if_valid_i & hazard;
   assign accept  = if_valid_i & ~rst & ~flush_i & ~squash_act & ~stall & (ex_ready_i | ~idex_q.valid);
   assign discard = if_valid_i & ~rst & ~flush_i & squash_act;

`ifdef ID_SQUASH_EN
   logic squash_q, squash_d;

   // Squash flag: armed by a taken branch, cleared by the discarded fetch or a flush
   always_comb begin
      squash_d = squash_q;
      if (flush_i)              squash_d = 1'b0;
      else if (accept && taken) squash_d = 1'b1;
      else if (discard)         squash_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) squash_q <= 1'b0;
      else     squash_q <= squash_d;
   end

   assign squash_act = squash_q;
   assign link_ofs   = 32'd4;
`else
   assign squash_act = 1'b0;
   assign link_ofs   = 32'd8;
`endif

   // Scoreboard: set on accepted load wins over the per-cycle decrement
   always_comb begin
      for (int i = 0; i < 32; i++) sb_d[i] = (sb_q[i] != 3'd0) ? sb_q[i] - 3'd1 : 3'd0;
      if (accept && is_lw && rt != 5'd0) sb_d[rt] = 3'(LOAD_LAT);
   end

   // ID/EX register next state; an invalid instruction loads a bubble and raises exc
   always_comb begin
      idex_d   = idex_q;
      exc_d    = 1'b0;
      exc_pc_d = exc_pc_q;
      if (flush_i) begin
         idex_d.valid = 1'b0;
      end else if (accept) begin
         if (inst_ok) begin
            idex_d.valid  = 1'b1;
            idex_d.aluop  = dec_aluop;
            idex_d.alusel = dec_alusel;
            idex_d.op1    = op1_dec;
            idex_d.op2    = op2_dec;
            idex_d.waddr  = dec_waddr;
            idex_d.we     = dec_we;
            idex_d.laddr  = is_link ? pc_i + link_ofs : '0;
            idex_d.mre    = is_lw;
            idex_d.mwe    = is_sw;
            idex_d.mwdata = is_sw ? rt_val : '0;
         end else begin
            idex_d   = '0;
            exc_d    = 1'b1;
            exc_pc_d = pc_i;
         end
      end else if (ex_ready_i) begin
         idex_d.valid = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idex_q   <= '0;
         sb_q     <= '0;
         exc_q    <= 1'b0;
         exc_pc_q <= '0;
      end else begin
         idex_q   <= idex_d;
         sb_q     <= sb_d;
         exc_q    <= exc_d;
         exc_pc_q <= exc_pc_d;
      end
   end

   assign if_ready_o = accept | discard;
   assign raddr1_o   = rst ? 5'd0 : rs;
   assign raddr2_o   = rst ? 5'd0 : rt;
   assign be_o       = accept & taken;
   assign baddr_o    = be_o ? target : '0;
   assign ex_valid_o = idex_q.valid;
   assign aluop_o    = idex_q.aluop;
   assign alusel_o   = idex_q.alusel;
   assign op1_o      = idex_q.op1;
   assign op2_o      = idex_q.op2;
   assign waddr_o    = idex_q.waddr;
   assign we_o       = idex_q.we;
   assign laddr_o    = idex_q.laddr;
   assign mre_o      = idex_q.mre;
   assign mwe_o      = idex_q.mwe;
   assign mwdata_o   = idex_q.mwdata;
   assign exc_o      = exc_q;
   assign exc_pc_o   = exc_pc_q;

endmodule
